// File: rtl/copro_host.sv
// rtl/copro_host.sv - host sequencer for a 32x32 multiply coprocessor; COPRO_HOST_TIMEOUT_EN adds a WAIT timeout
module copro_host #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        ck,
    input  logic        rb,
    input  logic        req,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] prod,
    output logic        err,
    output logic        start,
    input  logic        ready,
    output logic        dpsh,
    output logic        dpop,
    output logic [31:0] dinp,
    input  logic [31:0] dout
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_A, S_PUSH_B, S_GO, S_WAIT, S_POP_HI, S_POP_LO, S_DONE
    } state_t;

    state_t      state;
    logic        ready_q;
    logic [31:0] b_q;

`ifdef COPRO_HOST_TIMEOUT_EN
    logic [31:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    // Outputs are registered for the state being entered, so each strobe lines up with its state.
    always_ff @(posedge ck or negedge rb) begin
        if (!rb) begin
            state    <= S_IDLE;
            ready_q  <= 1'b0;
            b_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            start    <= 1'b0;
            dpsh     <= 1'b0;
            dpop     <= 1'b0;
            dinp     <= '0;
            prod     <= '0;
`ifdef COPRO_HOST_TIMEOUT_EN
            err      <= 1'b0;
            wait_cnt <= '0;
`endif
        end else begin
            ready_q <= ready;
            busy    <= 1'b1;
            done    <= 1'b0;
            start   <= 1'b0;
            dpsh    <= 1'b0;
            dpop    <= 1'b0;
            dinp    <= '0;
`ifdef COPRO_HOST_TIMEOUT_EN
            err     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state <= S_PUSH_A;
                        b_q   <= b;
                        dpsh  <= 1'b1;
                        dinp  <= a;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                S_PUSH_A: begin
                    state <= S_PUSH_B;
                    dpsh  <= 1'b1;
                    dinp  <= b_q;
                end
                S_PUSH_B: begin
                    state <= S_GO;
                    start <= 1'b1;
                end
                S_GO: begin
                    state <= S_WAIT;
`ifdef COPRO_HOST_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    // Only a fresh rising edge of ready counts; a level left over from before is ignored.
                    if (ready && !ready_q) begin
                        state <= S_POP_HI;
                        dpop  <= 1'b1;
                    end
`ifdef COPRO_HOST_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_CYC - 1) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
`endif
                end
                S_POP_HI: begin
                    state       <= S_POP_LO;
                    prod[63:32] <= dout;
                    dpop        <= 1'b1;
                end
                S_POP_LO: begin
                    state      <= S_DONE;
                    prod[31:0] <= dout;
                    done       <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_copro_host.sv
// tb/tb_copro_host.sv - directed self-checking bench for copro_host with a behavioural coprocessor
module tb_copro_host;

    logic        ck = 1'b0;
    logic        rb = 1'b0;
    logic        req = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] dout = '0;
    logic        busy, done, err, start, dpsh, dpop;
    logic [63:0] prod;
    logic [31:0] dinp;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] push_d[$];
    logic [63:0] prod_m = '0;
    int          pop_i = 0;
    int          n_start = 0, n_pop = 0, n_done = 0;
    int          cyc = 0, start_cyc = 0, done_cyc = 0;
    logic        prev_done = 1'b0;

    always #5 ck = ~ck;

    copro_host #(.TIMEOUT_CYC(16)) dut (
        .ck(ck), .rb(rb), .req(req), .a(a), .b(b),
        .busy(busy), .done(done), .prod(prod), .err(err),
        .start(start), .ready(ready), .dpsh(dpsh), .dpop(dpop),
        .dinp(dinp), .dout(dout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Coprocessor model plus per-cycle protocol checks, sampled mid-cycle.
    always @(negedge ck) begin
        cyc++;
        chk("excl", {63'b0, (start & dpsh) | (start & dpop) | (dpsh & dpop)}, 64'd0);
        if (!dpsh) chk("dinp_idle", {32'b0, dinp}, 64'd0);
        chk("done_1cyc", {63'b0, done & prev_done}, 64'd0);
        prev_done = done;
        if (dpsh) push_d.push_back(dinp);
        if (start) begin
            n_start++;
            start_cyc = cyc;
            pop_i = 0;
            if (push_d.size() >= 2)
                prod_m = {32'b0, push_d[push_d.size()-2]} * {32'b0, push_d[push_d.size()-1]};
        end
        if (dpop) begin
            n_pop++;
            dout = (pop_i == 0) ? prod_m[63:32] : prod_m[31:0];
            pop_i++;
        end else begin
            dout = 32'hBAD0BAD0;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge ck);
            #1;
        end
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        a = x;
        b = y;
        req = 1'b1;
        tick(1);
        req = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int lim);
        int k = 0;
        while (!start && k < lim) begin
            tick(1);
            k++;
        end
        chk({tag, "_start"}, {63'b0, start}, 64'd1);
    endtask

    task automatic wait_done(input string tag, input int lim);
        int k = 0;
        while (!done && k < lim) begin
            tick(1);
            k++;
        end
        chk({tag, "_done"}, {63'b0, done}, 64'd1);
    endtask

    task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input logic [63:0] exp);
        int d0 = n_done;
        issue(x, y);
        wait_start(tag, 10);
        tick(2);
        ready = 1'b1;
        wait_done(tag, 10);
        chk({tag, "_prod"}, prod, exp);
        chk({tag, "_err"}, {63'b0, err}, 64'd0);
        ready = 1'b0;
        tick(1);
        chk({tag, "_ndone"}, 64'(n_done - d0), 64'd1);
        chk({tag, "_hold"}, prod, exp);
    endtask

    initial begin
        int d0, p0, lows;

        tick(2);
        chk("rst_busy",  {63'b0, busy},  64'd0);
        chk("rst_done",  {63'b0, done},  64'd0);
        chk("rst_err",   {63'b0, err},   64'd0);
        chk("rst_start", {63'b0, start}, 64'd0);
        chk("rst_dpsh",  {63'b0, dpsh},  64'd0);
        chk("rst_dpop",  {63'b0, dpop},  64'd0);
        chk("rst_dinp",  {32'b0, dinp},  64'd0);
        chk("rst_prod",  prod,           64'd0);
        rb = 1'b1;
        tick(2);
        chk("idle_busy", {63'b0, busy}, 64'd0);

        // Basic product with full push/start/pop accounting and latency.
        push_d.delete();
        n_start = 0; n_pop = 0; n_done = 0;
        issue(32'h12345678, 32'hFEDCBA98);
        wait_start("basic", 10);
        tick(3);
        ready = 1'b1;
        wait_done("basic", 10);
        chk("basic_prod", prod, 64'h121FA00A35068740);
        chk("basic_err", {63'b0, err}, 64'd0);
        chk("basic_npush", 64'(push_d.size()), 64'd2);
        chk("basic_push0", {32'b0, push_d[0]}, 64'h12345678);
        chk("basic_push1", {32'b0, push_d[1]}, 64'hFEDCBA98);
        chk("basic_nstart", 64'(n_start), 64'd1);
        chk("basic_npop", 64'(n_pop), 64'd2);
        chk("basic_lat", 64'(done_cyc - start_cyc), 64'd6);
        ready = 1'b0;
        tick(1);
        chk("basic_done_low", {63'b0, done}, 64'd0);
        chk("basic_busy_low", {63'b0, busy}, 64'd0);
        chk("basic_ndone", 64'(n_done), 64'd1);

        op("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        op("zero", 32'h00000000, 32'hDEADBEEF, 64'd0);

        // Request during WAIT with different operands must be dropped.
        d0 = n_done; p0 = n_start;
        issue(32'd3, 32'd5);
        wait_start("ign", 10);
        tick(1);
        issue(32'd7, 32'd9);
        tick(1);
        ready = 1'b1;
        wait_done("ign", 10);
        chk("ign_prod", prod, 64'd15);
        ready = 1'b0;
        tick(6);
        chk("ign_ndone", 64'(n_done - d0), 64'd1);
        chk("ign_nstart", 64'(n_start - p0), 64'd1);
        chk("ign_busy", {63'b0, busy}, 64'd0);

        // ready already high entering WAIT must not trigger the pops.
        p0 = n_pop;
        issue(32'h00010000, 32'h00010000);
        ready = 1'b1;
        wait_start("lvl", 10);
        tick(5);
        chk("lvl_nopop_hi", 64'(n_pop - p0), 64'd0);
        chk("lvl_busy", {63'b0, busy}, 64'd1);
        ready = 1'b0;
        tick(2);
        chk("lvl_nopop_lo", 64'(n_pop - p0), 64'd0);
        ready = 1'b1;
        wait_done("lvl", 10);
        chk("lvl_prod", prod, 64'h0000000100000000);
        chk("lvl_npop", 64'(n_pop - p0), 64'd2);
        ready = 1'b0;
        tick(1);

        // req raised in the done cycle is not accepted.
        issue(32'd2, 32'd3);
        wait_start("dreq", 10);
        tick(2);
        ready = 1'b1;
        wait_done("dreq", 10);
        p0 = push_d.size();
        a = 32'd4; b = 32'd4; req = 1'b1;
        tick(1);
        req = 1'b0;
        ready = 1'b0;
        chk("dreq_busy", {63'b0, busy}, 64'd0);
        tick(2);
        chk("dreq_busy2", {63'b0, busy}, 64'd0);
        chk("dreq_nopush", 64'(push_d.size() - p0), 64'd0);
        chk("dreq_prod", prod, 64'd6);

        // Asynchronous reset in WAIT aborts without done.
        issue(32'd5, 32'd7);
        wait_start("rst", 10);
        tick(2);
        d0 = n_done;
        rb = 1'b0;
        #1;
        chk("arst_busy",  {63'b0, busy},  64'd0);
        chk("arst_done",  {63'b0, done},  64'd0);
        chk("arst_start", {63'b0, start}, 64'd0);
        chk("arst_dpsh",  {63'b0, dpsh},  64'd0);
        chk("arst_dpop",  {63'b0, dpop},  64'd0);
        chk("arst_dinp",  {32'b0, dinp},  64'd0);
        chk("arst_err",   {63'b0, err},   64'd0);
        chk("arst_prod",  prod,           64'd0);
        tick(2);
        rb = 1'b1;
        tick(1);
        chk("arst_ndone", 64'(n_done - d0), 64'd0);
        op("post_rst", 32'd6, 32'd7, 64'd42);

        // ready stuck low.
        d0 = n_done; p0 = n_pop;
        issue(32'd9, 32'd9);
        wait_start("tmo", 10);
`ifdef COPRO_HOST_TIMEOUT_EN
        wait_done("tmo", 40);
        chk("tmo_err", {63'b0, err}, 64'd1);
        chk("tmo_lat", 64'(done_cyc - start_cyc), 64'd17);
        chk("tmo_npop", 64'(n_pop - p0), 64'd0);
        chk("tmo_prod", prod, 64'd42);
        tick(1);
        chk("tmo_err_low", {63'b0, err}, 64'd0);
        chk("tmo_busy", {63'b0, busy}, 64'd0);
`else
        lows = 0;
        repeat (1000) begin
            tick(1);
            if (!busy) lows++;
        end
        chk("stuck_busy", 64'(lows), 64'd0);
        chk("stuck_ndone", 64'(n_done - d0), 64'd0);
        chk("stuck_npop", 64'(n_pop - p0), 64'd0);
        chk("stuck_err", {63'b0, err}, 64'd0);
        rb = 1'b0;
        tick(1);
        rb = 1'b1;
        tick(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
